// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one external word-memory port between the instruction cache
//   (port 0) and the data cache (port 1). Requests are arbitrated
//   round-robin and forwarded to memory with no added latency. Every
//   accepted read records its owner in a small FIFO, so the in-order read
//   responses coming back from memory are steered to the port that issued
//   them.
//
// Parameters:
//   OUTSTANDING   maximum number of reads in flight (power of two, >= 2)
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_pN_addr/ren/wen/wdata port N request (addr bits[1:0] ignored)
//   o_pN_ready              port N request accepted this cycle
//   o_pN_rdata/valid        port N read response (valid is a 1-cycle pulse)
//   i_mem_ready             memory accepts a request this cycle
//   o_mem_addr/ren/wen/wdata forwarded request (addr bits[1:0] forced to 0)
//   i_mem_rdata/valid       memory read response
//   o_err                   sticky: a response arrived with no read pending
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int OUTSTANDING = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [31:0] i_p0_addr,
    input  logic        i_p0_ren,
    input  logic        i_p0_wen,
    input  logic [31:0] i_p0_wdata,
    output logic        o_p0_ready,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_valid,

    input  logic [31:0] i_p1_addr,
    input  logic        i_p1_ren,
    input  logic        i_p1_wen,
    input  logic [31:0] i_p1_wdata,
    output logic        o_p1_ready,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_valid,

    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid,

    output logic        o_err
);

    localparam int PTR_W = $clog2(OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(OUTSTANDING);

    // Identity of an upstream port; used both for the round-robin history
    // and for the owner tag stored with every outstanding read.
    typedef enum logic {
        PORT_ICACHE = 1'b0,
        PORT_DCACHE = 1'b1
    } port_e;

    // Registered state
    port_e            last_grant_q, last_grant_d;
    port_e            owner_q [OUTSTANDING];
    port_e            owner_d [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    // Combinational decode
    logic        p0_req, p1_req;
    logic        p0_elig, p1_elig;
    logic        grant0, grant1;
    logic        fifo_empty, fifo_full;
    logic        pop, push, accept;
    logic        read_room;
    port_e       head_owner;

    // Request decode, eligibility and round-robin grant. A port asserting
    // both ren and wen is treated as a read, so wen only matters when ren is
    // low. A read needs a free owner slot, which also exists when the FIFO is
    // full but its head is retiring this very cycle. Nothing is granted while
    // reset is asserted so no request can slip through during reset.
    always_comb begin
        p0_req     = i_p0_ren | i_p0_wen;
        p1_req     = i_p1_ren | i_p1_wen;

        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_FULL);
        pop        = i_mem_valid & ~fifo_empty;
        read_room  = ~fifo_full | pop;

        p0_elig    = p0_req & (~i_p0_ren | read_room) & ~i_rst;
        p1_elig    = p1_req & (~i_p1_ren | read_room) & ~i_rst;

        // With both ports eligible, the one that was not granted last wins.
        grant0     = p0_elig & (~p1_elig | (last_grant_q == PORT_DCACHE));
        grant1     = p1_elig & (~p0_elig | (last_grant_q == PORT_ICACHE));
    end

    // Forward the granted request to memory. The bus is driven to all zeros
    // when nobody is granted so idle cycles look clean downstream.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_wdata = '0;
        if (grant0) begin
            o_mem_addr  = i_p0_addr & ~32'h3;
            o_mem_ren   = i_p0_ren;
            o_mem_wen   = i_p0_wen & ~i_p0_ren;
            o_mem_wdata = i_p0_wdata;
        end else if (grant1) begin
            o_mem_addr  = i_p1_addr & ~32'h3;
            o_mem_ren   = i_p1_ren;
            o_mem_wen   = i_p1_wen & ~i_p1_ren;
            o_mem_wdata = i_p1_wdata;
        end
    end

    // Handshake back to the caches. The loser sees ready low and holds.
    always_comb begin
        o_p0_ready = grant0 & i_mem_ready;
        o_p1_ready = grant1 & i_mem_ready;
        accept     = o_p0_ready | o_p1_ready;
        push       = accept & o_mem_ren;
    end

    // Response steering: the FIFO head names the owner of the response now
    // on the bus. Read data itself is broadcast to both ports unqualified.
    always_comb begin
        head_owner = owner_q[rd_ptr_q];
        o_p0_valid = pop & (head_owner == PORT_ICACHE);
        o_p1_valid = pop & (head_owner == PORT_DCACHE);
        o_p0_rdata = i_mem_rdata;
        o_p1_rdata = i_mem_rdata;
        o_err      = err_q;
    end

    // Next-state for the owner FIFO, round-robin history and error flag.
    // A simultaneous push and pop advances both pointers and leaves the
    // count unchanged; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q;

        if (accept) begin
            last_grant_d = grant1 ? PORT_DCACHE : PORT_ICACHE;
        end

        if (push) begin
            owner_d[wr_ptr_q] = grant1 ? PORT_DCACHE : PORT_ICACHE;
            wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A response with nothing outstanding is dropped and remembered.
        if (i_mem_valid && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    // State registers. Reset forgets all outstanding reads, so responses
    // to reads issued before reset later show up as spurious and set o_err.
    // The history resets to port 1 so port 0 wins the first contention.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_grant_q <= PORT_DCACHE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < OUTSTANDING; i++) begin
                owner_q[i] <= PORT_ICACHE;
            end
        end else begin
            last_grant_q <= last_grant_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            for (int i = 0; i < OUTSTANDING; i++) begin
                owner_q[i] <= owner_d[i];
            end
        end
    end

endmodule
